// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: ROM address/word types,
// capacity and the byte-lane insert helper used by the word packer.
package imem_loader_pkg;

  typedef logic [7:0]  RomAddress;
  typedef logic [31:0] UWord;

  localparam int ROM_BYTES = 2 ** $bits(RomAddress);
  // Remaining-byte down-counter must hold ROM_BYTES itself, hence the extra bit.
  localparam int CNT_W     = $clog2(ROM_BYTES) + 1;

  function automatic UWord insert_byte(input UWord w, input logic [1:0] lane,
                                       input logic [7:0] b);
    UWord r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; clears after each
// emitted word so unfilled lanes of a short final word read as zero.
module imem_loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_clear,
  input  logic       i_push,
  input  logic       i_emit,
  input  logic [7:0] i_byte,
  output UWord       o_word_ins,
  output logic       o_full
);

  UWord       r_word;
  logic [1:0] r_lane;

  assign o_word_ins = insert_byte(r_word, r_lane, i_byte);
  assign o_full     = (r_lane == 2'd3);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_push) begin
      if (i_emit) begin
        r_word <= '0;
        r_lane <= '0;
      end else begin
        r_word <= o_word_ins;
        r_lane <= r_lane + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as aligned
// 32-bit words while holding the CPU; flags oversize images as an error.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_in_data,
  output logic       o_mem_we,
  output RomAddress  o_mem_addr,
  output UWord       o_mem_wdata,
  output logic       o_cpu_hold,
  output logic       o_done,
  output logic       o_error
);

  // state   | meaning
  // S_IDLE  | after reset, waiting for start
  // S_LEN   | collecting 4-byte little-endian length
  // S_DATA  | collecting payload, writing words
  // S_FLUSH | write cycle of the final word
  // S_DONE  | load complete, CPU released
  // S_ERROR | length too large, CPU held
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_FLUSH, S_DONE, S_ERROR} state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_len_cnt;
  logic [23:0]      r_len;
  logic [CNT_W-1:0] r_remain;
  RomAddress        r_addr;
  logic             r_mem_we;
  RomAddress        r_mem_addr;
  UWord             r_mem_wdata;

  logic w_accept, w_restart, w_len_last, w_data_last, w_emit, w_full;
  UWord w_len_full, w_word_ins;

  assign w_accept    = i_in_valid && o_in_ready;
  assign w_restart   = i_start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign w_len_full  = {i_in_data, r_len};
  assign w_len_last  = w_accept && (r_state == S_LEN) && (r_len_cnt == 2'd3);
  assign w_data_last = w_accept && (r_state == S_DATA) && (r_remain == CNT_W'(1));
  assign w_emit      = w_accept && (r_state == S_DATA) && (w_full || r_remain == CNT_W'(1));

  imem_loader_word_packer u_packer (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_clear    (w_restart),
    .i_push     (w_accept && (r_state == S_DATA)),
    .i_emit     (w_emit),
    .i_byte     (i_in_data),
    .o_word_ins (w_word_ins),
    .o_full     (w_full)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (i_start) w_next = S_LEN;
      S_LEN: if (w_len_last) begin
        if (w_len_full == '0)                     w_next = S_DONE;
        else if (w_len_full > UWord'(ROM_BYTES)) w_next = S_ERROR;
        else                                      w_next = S_DATA;
      end
      S_DATA:  if (w_data_last) w_next = S_FLUSH;
      S_FLUSH: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready = (r_state == S_LEN) || (r_state == S_DATA);
    o_cpu_hold = (r_state != S_DONE);
    o_done     = (r_state == S_DONE);
    o_error    = (r_state == S_ERROR);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_len_cnt   <= '0;
      r_len       <= '0;
      r_remain    <= '0;
      r_addr      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_emit;
      if (w_restart) begin
        r_len_cnt <= '0;
        r_len     <= '0;
        r_addr    <= '0;
      end
      if (w_accept && r_state == S_LEN) begin
        if (r_len_cnt != 2'd3) r_len[{r_len_cnt, 3'b000} +: 8] <= i_in_data;
        else                   r_remain <= w_len_full[CNT_W-1:0];
        r_len_cnt <= r_len_cnt + 2'd1;
      end
      if (w_accept && r_state == S_DATA) r_remain <= r_remain - CNT_W'(1);
      if (w_emit) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= w_word_ins;
        r_addr      <= r_addr + RomAddress'(4);
      end
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load sessions plus hand-written
// sequences for mid-session reset and a full-capacity image.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_in_valid = 1'b0;
  logic [7:0] i_in_data = '0;
  logic       o_in_ready, o_mem_we, o_cpu_hold, o_done, o_error;
  RomAddress  o_mem_addr;
  UWord       o_mem_wdata;

  imem_loader dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_start     (i_start),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_cpu_hold  (o_cpu_hold),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0]  len;
    logic [127:0] pay;
    logic [7:0]   exp_n;
    logic [95:0]  exp_w;
    logic         exp_done;
    logic         exp_err;
    logic         gaps;
    logic         poke;
  } vec_t;

  typedef struct packed {
    RomAddress a;
    UWord      d;
  } wr_t;

  wr_t  wq[$];
  vec_t vecs[9];
  int   n_pass = 0;
  int   n_total = 0;
  int   stalls = 0;

  always @(negedge i_clk) if (o_mem_we) wq.push_back('{a: o_mem_addr, d: o_mem_wdata});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_in_valid = 1'b1;
    i_in_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge i_clk);
      if (o_in_ready) begin
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        return;
      end
      stalls++;
    end
    i_in_valid = 1'b0;
    n_total++;
    $display("FAIL send_timeout: in_ready stayed 0, byte %0h not taken", b);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_end(output int lat);
    lat = 0;
    while (!(o_done || o_error) && lat < 100) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int exp_lat;
    string s;
    wq.delete();
    stalls = 0;
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(v.len[8*k +: 8]);
    if (!v.exp_err && v.len != 0) begin
      for (int k = 0; k < int'(v.len); k++) begin
        if (v.gaps && $urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 2)) @(posedge i_clk);
          #1;
        end
        if (v.poke && k == 2) i_start = 1'b1;
        send_byte(v.pay[8*k +: 8]);
        i_start = 1'b0;
      end
      s = $sformatf("v%0d_flush_ready", idx); chk(s, 64'(o_in_ready), 64'd0);
      s = $sformatf("v%0d_flush_we", idx);    chk(s, 64'(o_mem_we), 64'd1);
      s = $sformatf("v%0d_flush_done", idx);  chk(s, 64'(o_done), 64'd0);
    end
    exp_lat = (v.exp_err || v.len == 0) ? 0 : 1;
    wait_end(lat);
    s = $sformatf("v%0d_latency", idx);  chk(s, 64'(lat), 64'(exp_lat));
    repeat (3) @(posedge i_clk);
    #1;
    s = $sformatf("v%0d_done", idx);     chk(s, 64'(o_done), 64'(v.exp_done));
    s = $sformatf("v%0d_error", idx);    chk(s, 64'(o_error), 64'(v.exp_err));
    s = $sformatf("v%0d_cpu_hold", idx); chk(s, 64'(o_cpu_hold), 64'(!v.exp_done));
    s = $sformatf("v%0d_ready", idx);    chk(s, 64'(o_in_ready), 64'd0);
    s = $sformatf("v%0d_stalls", idx);   chk(s, 64'(stalls), 64'd0);
    s = $sformatf("v%0d_nwrites", idx);  chk(s, 64'(wq.size()), 64'(v.exp_n));
    for (int j = 0; j < int'(v.exp_n) && j < wq.size(); j++) begin
      s = $sformatf("v%0d_addr%0d", idx, j); chk(s, 64'(wq[j].a), 64'(4 * j));
      s = $sformatf("v%0d_data%0d", idx, j); chk(s, 64'(wq[j].d), 64'(v.exp_w[32*j +: 32]));
    end
  endtask

  initial begin
    int lat;
    int bad;
    vecs[0] = '{len: 32'd8,   pay: 128'h00000037_00000013, exp_n: 8'd2,
                exp_w: 96'h00000000_00000037_00000013, exp_done: 1'b1, exp_err: 1'b0, gaps: 1'b0, poke: 1'b0};
    vecs[1] = '{len: 32'd6,   pay: 128'h0605_04030201, exp_n: 8'd2,
                exp_w: 96'h00000000_00000605_04030201, exp_done: 1'b1, exp_err: 1'b0, gaps: 1'b0, poke: 1'b0};
    vecs[2] = '{len: 32'd257, pay: 128'h0, exp_n: 8'd0,
                exp_w: 96'h0, exp_done: 1'b0, exp_err: 1'b1, gaps: 1'b0, poke: 1'b0};
    vecs[3] = '{len: 32'd4,   pay: 128'hDDCCBBAA, exp_n: 8'd1,
                exp_w: 96'hDDCCBBAA, exp_done: 1'b1, exp_err: 1'b0, gaps: 1'b0, poke: 1'b0};
    vecs[4] = '{len: 32'd12,  pay: 128'h1B1A1918_17161514_13121110, exp_n: 8'd3,
                exp_w: 96'h1B1A1918_17161514_13121110, exp_done: 1'b1, exp_err: 1'b0, gaps: 1'b0, poke: 1'b0};
    vecs[5] = '{len: 32'd12,  pay: 128'h1B1A1918_17161514_13121110, exp_n: 8'd3,
                exp_w: 96'h1B1A1918_17161514_13121110, exp_done: 1'b1, exp_err: 1'b0, gaps: 1'b1, poke: 1'b0};
    vecs[6] = '{len: 32'd0,   pay: 128'h0, exp_n: 8'd0,
                exp_w: 96'h0, exp_done: 1'b1, exp_err: 1'b0, gaps: 1'b0, poke: 1'b0};
    vecs[7] = '{len: 32'd1,   pay: 128'h5A, exp_n: 8'd1,
                exp_w: 96'h0000005A, exp_done: 1'b1, exp_err: 1'b0, gaps: 1'b0, poke: 1'b0};
    vecs[8] = '{len: 32'd8,   pay: 128'h08070605_04030201, exp_n: 8'd2,
                exp_w: 96'h00000000_08070605_04030201, exp_done: 1'b1, exp_err: 1'b0, gaps: 1'b0, poke: 1'b1};

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", 64'(o_in_ready), 64'd0);
    chk("rst_we",    64'(o_mem_we), 64'd0);
    chk("rst_addr",  64'(o_mem_addr), 64'd0);
    chk("rst_wdata", 64'(o_mem_wdata), 64'd0);
    chk("rst_done",  64'(o_done), 64'd0);
    chk("rst_error", 64'(o_error), 64'd0);
    chk("rst_hold",  64'(o_cpu_hold), 64'd1);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("idle_ready", 64'(o_in_ready), 64'd0);
    chk("idle_hold",  64'(o_cpu_hold), 64'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset asserted between clock edges after 5 of 8 payload bytes.
    wq.delete();
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(8'(k == 0 ? 8 : 0));
    for (int k = 1; k <= 5; k++) send_byte(8'(k * 17));
    i_reset_n = 1'b0;
    #1;
    chk("arst_we",    64'(o_mem_we), 64'd0);
    chk("arst_addr",  64'(o_mem_addr), 64'd0);
    chk("arst_wdata", 64'(o_mem_wdata), 64'd0);
    chk("arst_ready", 64'(o_in_ready), 64'd0);
    chk("arst_done",  64'(o_done), 64'd0);
    chk("arst_error", 64'(o_error), 64'd0);
    chk("arst_hold",  64'(o_cpu_hold), 64'd1);
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (6) @(posedge i_clk);
    #1;
    chk("arst_nwrites", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) begin
      chk("arst_data0", 64'(wq[0].d), 64'h44332211);
      chk("arst_addr0", 64'(wq[0].a), 64'd0);
    end
    chk("arst_idle_ready", 64'(o_in_ready), 64'd0);

    // Full-capacity image: the last write lands at ROM_BYTES-4.
    wq.delete();
    stalls = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    for (int k = 0; k < ROM_BYTES; k++) send_byte(8'(k));
    wait_end(lat);
    chk("full_latency", 64'(lat), 64'd1);
    chk("full_done",    64'(o_done), 64'd1);
    chk("full_error",   64'(o_error), 64'd0);
    chk("full_stalls",  64'(stalls), 64'd0);
    chk("full_nwrites", 64'(wq.size()), 64'(ROM_BYTES / 4));
    bad = 0;
    for (int j = 0; j < wq.size(); j++) begin
      if (32'(wq[j].a) != 32'(4 * j) ||
          wq[j].d != {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)}) bad++;
    end
    chk("full_bad_words", 64'(bad), 64'd0);
    if (wq.size() > 0) begin
      chk("full_last_addr", 64'(wq[wq.size()-1].a), 64'(ROM_BYTES - 4));
      chk("full_last_data", 64'(wq[wq.size()-1].d), 64'hFFFEFDFC);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: none; capacity is derived from the shared RomAddress width (ROM_BYTES = 2**$bits(RomAddress)).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; begins a load session.
REQ-005 in_valid  input  1  byte stream valid.
REQ-006 in_ready  output  1  loader accepts a byte this cycle.
REQ-007 in_data  input  8  byte stream payload.
REQ-008 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 mem_addr  output  RomAddress  byte address of the word written; always word-aligned.
REQ-010 mem_wdata  output  UWord  word written, little-endian assembled.
REQ-011 cpu_hold  output  1  holds the pipeline while memory is being loaded.
REQ-012 done  output  1  sticky; load completed successfully.
REQ-013 error  output  1  sticky; declared length exceeds ROM_BYTES.

Function
REQ-014 States: IDLE, LEN, DATA, FLUSH, DONE, ERROR.
REQ-015 Byte transfer occurs only on cycles with in_valid && in_ready.
REQ-016 IDLE: in_ready=0; start -> LEN; clears done, error, byte counter, address=0, cpu_hold=1.
REQ-017 LEN: in_ready=1; accepts 4 bytes forming a 32-bit little-endian byte count L (first byte = bits 7:0).
REQ-018 After the 4th LEN byte: L=0 -> DONE; L>ROM_BYTES -> ERROR; otherwise -> DATA.
REQ-019 DATA: in_ready=1; byte k of payload lands in lane (k mod 4) of the assembly word.
REQ-020 When lane 3 is filled, or the L-th byte is accepted, the next cycle drives mem_we=1 with mem_wdata=assembled word, mem_addr=current address; unfilled lanes are 0.
REQ-021 Address increments by 4 after each write; the assembly register clears for the next word.
REQ-022 A byte may be accepted in the same cycle mem_we is high (full throughput, one byte/cycle, no bubble).
REQ-023 After the L-th byte: -> FLUSH (in_ready=0) for the write cycle, then -> DONE.
REQ-024 DONE: done=1, cpu_hold=0, in_ready=0; start -> LEN (new session).
REQ-025 ERROR: error=1, cpu_hold=1, in_ready=0, no writes; only start or reset exits.
REQ-026 start outside IDLE/DONE/ERROR is ignored.
REQ-027 L = ROM_BYTES is legal; the last write is at ROM_BYTES-4 and the address never wraps.
REQ-028 mem_we is never asserted outside DATA/FLUSH; mem_addr/mem_wdata are don't-care when mem_we=0 but registered (no combinational path from in_data).

Reset
REQ-029 reset_n low asynchronously forces IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, cpu_hold=1.
REQ-030 Reset mid-session aborts it; no partial word is written and no write occurs until a new start.

Structure
REQ-031 RomAddress, UWord and ROM_BYTES live in the shared types package; the state enum is local.
REQ-032 One sub-module is natural: word_packer (lane select, byte insert, clear, full flag).
REQ-033 The loader drives the write port of a dual-port instruction memory whose read port is unchanged.

Verification
REQ-034 start; L=8; bytes 13 00 00 00 37 00 00 00 -> writes 0x00000013@0x0, 0x00000037@0x4; done=1; cpu_hold=0.
REQ-035 L=6; payload 01..06 -> 0x04030201@0x0, 0x00000605@0x4; FLUSH then DONE.
REQ-036 L=ROM_BYTES+1 -> error=1, zero mem_we pulses, cpu_hold=1; next start with L=4 -> one write, done=1, error=0.
REQ-037 in_valid toggled randomly, L=12 -> three writes, identical data to the continuous-valid case.
REQ-038 reset_n low after 5 payload bytes of L=8 -> exactly one write observed (first word), all outputs at reset values asynchronously.
REQ-039 L=0 -> DONE immediately after the 4th length byte, no writes.
